// File: rtl/apb_global_pkg.sv
// rtl/apb_global_pkg.sv - shared APB widths, slave count and arbiter state type
package apb_global_pkg;

    localparam int NO_OF_SLAVES  = 4;
    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int NO_OF_REQ     = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DECERR
    } apb_arb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin pick, searching upward from rr_ptr+1 with wrap
module apb_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(rr_ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
        grant = any ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin sharing of one APB master port among local requesters
module apb_master_arbiter #(
    parameter int  NO_OF_REQ      = apb_global_pkg::NO_OF_REQ,
    parameter int  REGION_BITS    = 12,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int NS             = apb_global_pkg::NO_OF_SLAVES,
    localparam int AW             = apb_global_pkg::ADDRESS_WIDTH,
    localparam int DW             = apb_global_pkg::DATA_WIDTH,
    localparam int SW             = DW / 8,
    localparam int IW             = $clog2(NO_OF_REQ),
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic [NO_OF_REQ-1:0]    req_valid,
    output logic [NO_OF_REQ-1:0]    req_ready,
    input  logic [NO_OF_REQ*AW-1:0] req_addr,
    input  logic [NO_OF_REQ-1:0]    req_write,
    input  logic [NO_OF_REQ*DW-1:0] req_wdata,
    input  logic [NO_OF_REQ*SW-1:0] req_strb,
    input  logic [NO_OF_REQ*3-1:0]  req_prot,
    output logic [NO_OF_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]           rsp_rdata,
    output logic                    rsp_slverr,
    output logic [NS-1:0]           pselx,
    output logic                    penable,
    output logic [AW-1:0]           paddr,
    output logic                    pwrite,
    output logic [DW-1:0]           pwdata,
    output logic [SW-1:0]           pstrb,
    output logic [2:0]              pprot,
    input  logic                    pready,
    input  logic [DW-1:0]           prdata,
    input  logic                    pslverr
);

    apb_global_pkg::apb_arb_state_e state;

    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        grant_idx;
    logic [NO_OF_REQ-1:0] grant;
    logic                 grant_any;
    logic [TW-1:0]        tmo_cnt;

    logic [AW-1:0] addr_arr  [NO_OF_REQ];
    logic [DW-1:0] wdata_arr [NO_OF_REQ];
    logic [SW-1:0] strb_arr  [NO_OF_REQ];
    logic [2:0]    prot_arr  [NO_OF_REQ];

    for (genvar g = 0; g < NO_OF_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
        assign strb_arr[g]  = req_strb[g*SW +: SW];
        assign prot_arr[g]  = req_prot[g*3 +: 3];
    end

    logic [AW-1:0] sel_addr;
    logic [AW-1:0] sel_slave;
    logic          sel_write;
    logic          decerr;

    assign sel_addr  = addr_arr[grant_idx];
    assign sel_write = req_write[grant_idx];
    assign sel_slave = sel_addr >> REGION_BITS;
    assign decerr    = (sel_slave >= AW'(NS));

    apb_rr_arbiter #(
        .N  (NO_OF_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Acceptance is only offered while idle, so at most one request is in flight.
    assign req_ready = (state == apb_global_pkg::IDLE) ? grant : '0;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state      <= apb_global_pkg::IDLE;
            rr_ptr     <= IW'(NO_OF_REQ - 1);
            owner      <= '0;
            tmo_cnt    <= '0;
            pselx      <= '0;
            penable    <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
            pprot      <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                apb_global_pkg::IDLE: begin
                    if (grant_any) begin
                        rr_ptr <= grant_idx;
                        owner  <= grant_idx;
                        paddr  <= sel_addr;
                        pwrite <= sel_write;
                        pwdata <= wdata_arr[grant_idx];
                        pstrb  <= sel_write ? strb_arr[grant_idx] : '0;
                        pprot  <= prot_arr[grant_idx];
                        if (decerr) begin
                            state <= apb_global_pkg::DECERR;
                        end else begin
                            state <= apb_global_pkg::SETUP;
                            pselx <= NS'(1) << sel_slave;
                        end
                    end
                end
                apb_global_pkg::SETUP: begin
                    penable <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= apb_global_pkg::ACCESS;
                end
                apb_global_pkg::ACCESS: begin
                    if (pready) begin
                        rsp_valid  <= NO_OF_REQ'(1) << owner;
                        rsp_rdata  <= pwrite ? '0 : prdata;
                        rsp_slverr <= pslverr;
                        pselx      <= '0;
                        penable    <= 1'b0;
                        state      <= apb_global_pkg::IDLE;
                    end else if (tmo_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
                        // This cycle is the last allowed wait; abandon the slave.
                        rsp_valid  <= NO_OF_REQ'(1) << owner;
                        rsp_rdata  <= '0;
                        rsp_slverr <= 1'b1;
                        pselx      <= '0;
                        penable    <= 1'b0;
                        tmo_cnt    <= TW'(TIMEOUT_CYCLES);
                        state      <= apb_global_pkg::IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                apb_global_pkg::DECERR: begin
                    rsp_valid  <= NO_OF_REQ'(1) << owner;
                    rsp_rdata  <= '0;
                    rsp_slverr <= 1'b1;
                    state      <= apb_global_pkg::IDLE;
                end
                default: state <= apb_global_pkg::IDLE;
            endcase
        end
    end

endmodule
